data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the external async data-memory interface: services multi-channel read/write requests issued by the data memory controller or cache.
- Holds a 2^ADDR_BITS x DATA_BITS storage array, a backdoor preload port, and independent per-channel read and write FSMs with configurable fixed latency.
- Used as the RTL memory model in full-GPU simulation and as the on-chip data SRAM wrapper.

Parameters:
- ADDR_BITS, 8, address width (array depth 2^ADDR_BITS)
- DATA_BITS, 8, data word width
- NUM_CHANNELS, 4, number of independent request channels
- READ_LATENCY, 2, cycles from request acceptance to read_ready; legal range >=1
- WRITE_LATENCY, 1, cycles from request acceptance to write_ready; legal range >=1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- load_enable  in  1  backdoor write strobe
- load_address  in  ADDR_BITS  backdoor write address
- load_data  in  DATA_BITS  backdoor write data
- mem_read_valid  in  NUM_CHANNELS  per-channel read request
- mem_read_address  in  ADDR_BITS x NUM_CHANNELS (unpacked)  read address
- mem_read_ready  out  NUM_CHANNELS  one-cycle read response strobe
- mem_read_data  out  DATA_BITS x NUM_CHANNELS (unpacked)  read data, valid while ready high
- mem_write_valid  in  NUM_CHANNELS  per-channel write request
- mem_write_address  in  ADDR_BITS x NUM_CHANNELS (unpacked)  write address
- mem_write_data  in  DATA_BITS x NUM_CHANNELS (unpacked)  write data
- mem_write_ready  out  NUM_CHANNELS  one-cycle write acknowledge strobe

Behaviour:
- Reset (sampled at posedge):
  - All ready bits 0, all read_data 0, all FSMs IDLE, latency counters 0, array cleared to 0.
  - load_enable is ignored while reset is high.
- Each channel has two independent FSMs, read and write, each with states IDLE, WAIT, RESP and REARM.
- IDLE: valid high at edge k -> latch address (and write data), load counter with LATENCY-1, go WAIT, or go directly to RESP when LATENCY==1.
- WAIT: counter decrements each edge; at 0 go RESP. Ready is therefore high for exactly the cycle after edge k+LATENCY.
  - Address and data changes after acceptance are ignored.
- Abort: valid sampled low in WAIT -> return to IDLE, no ready pulse, no write commit.
- RESP: ready=1 for exactly one cycle, then go REARM unconditionally.
- REARM: ready=0; go IDLE on the first edge where valid is sampled low, without accepting at that edge. Valid held high stays in REARM, so the minimum gap between requests is 1 low cycle.
- Read data: on the edge entering RESP, mem_read_data[ch] <= array[latched_addr].
  - Writes committing at that same edge are not visible: old data is returned.
  - mem_read_data holds its value after RESP until the next response.
- Write commit: array[latched_addr] <= latched_data on the edge entering RESP, i.e. the commit is visible to reads entering RESP on any later edge.
- Write priority on the same address at the same edge: the highest-index channel commits; load_enable has the lowest priority (any channel write overrides load).
- Reset mid-operation: every FSM returns to IDLE, in-flight writes are dropped, ready is deasserted the next cycle.
- Address arithmetic: no wrap or offset; the full ADDR_BITS range is addressable.

Test Plan:
- Preload via load port: addr 0x10=0xA5. Ch0 read 0x10 with valid held from edge 5 -> read_ready[0] high only in the cycle after edge 7 (READ_LATENCY=2), data 0xA5; then REARM until valid drops.
- Ch2 writes 0x3C to 0x20; after ready drops, ch1 reads 0x20 -> returns 0x3C. Ch1 read entering RESP on the same edge as the write commit -> returns old value 0x00.
- Channels 0,1,3 write 0x11, 0x22, 0x33 to 0x40 on the same edge, plus load_enable of 0x44 to 0x40 -> read back 0x33.
- All 4 channels read different preloaded addresses concurrently -> all ready bits pulse on the same cycle, each with the correct data.
- Ch0 write valid dropped after 0 wait cycles with WRITE_LATENCY=3 -> no write_ready, memory unchanged.
- Reset asserted during WAIT -> ready stays 0, array reads 0x00, a new request after reset is serviced normally.

Source files
------------

// File: rtl/data_mem_if.sv
// Multi-channel request/response bundle between a data-memory requester
// (controller or cache) and the memory responder.
interface data_mem_if #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4
);
  logic [NUM_CHANNELS-1:0] mem_read_valid;
  logic [ADDR_BITS-1:0]    mem_read_address  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mem_read_ready;
  logic [DATA_BITS-1:0]    mem_read_data     [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mem_write_valid;
  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: storage array with backdoor preload and independent
// per-channel fixed-latency read and write FSMs (IDLE/WAIT/RESP/REARM).
module data_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_enable,
  input  logic [ADDR_BITS-1:0] load_address,
  input  logic [DATA_BITS-1:0] load_data,
  data_mem_if.slave            mem
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int RCW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int WCW   = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
  localparam logic [RCW-1:0] RD_LOAD = RCW'(READ_LATENCY - 1);
  localparam logic [WCW-1:0] WR_LOAD = WCW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_REARM} state_e;

  state_e               rd_state_q [NUM_CHANNELS], rd_state_d [NUM_CHANNELS];
  logic [RCW-1:0]       rd_cnt_q   [NUM_CHANNELS], rd_cnt_d   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] rd_addr_q  [NUM_CHANNELS], rd_addr_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rd_data_q  [NUM_CHANNELS], rd_data_d  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] rd_fire;

  state_e               wr_state_q [NUM_CHANNELS], wr_state_d [NUM_CHANNELS];
  logic [WCW-1:0]       wr_cnt_q   [NUM_CHANNELS], wr_cnt_d   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] wr_addr_q  [NUM_CHANNELS], wr_addr_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wr_data_q  [NUM_CHANNELS], wr_data_d  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] wr_fire;

  logic [DATA_BITS-1:0] mem_q [DEPTH], mem_d [DEPTH];

  // *_fire marks the edge entering RESP; the *_d address/data is the one to use there.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rd_state_d[c] = rd_state_q[c];
      rd_cnt_d[c]   = rd_cnt_q[c];
      rd_addr_d[c]  = rd_addr_q[c];
      rd_fire[c]    = 1'b0;
      case (rd_state_q[c])
        S_IDLE: if (mem.mem_read_valid[c]) begin
          rd_addr_d[c] = mem.mem_read_address[c];
          rd_cnt_d[c]  = RD_LOAD;
          if (READ_LATENCY == 1) begin
            rd_state_d[c] = S_RESP;
            rd_fire[c]    = 1'b1;
          end else begin
            rd_state_d[c] = S_WAIT;
          end
        end
        S_WAIT: begin
          if (!mem.mem_read_valid[c]) begin
            rd_state_d[c] = S_IDLE;
          end else if (rd_cnt_q[c] == '0) begin
            rd_state_d[c] = S_RESP;
            rd_fire[c]    = 1'b1;
          end else begin
            rd_cnt_d[c] = rd_cnt_q[c] - RCW'(1);
          end
        end
        S_RESP:  rd_state_d[c] = S_REARM;
        S_REARM: if (!mem.mem_read_valid[c]) rd_state_d[c] = S_IDLE;
        default: rd_state_d[c] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      wr_state_d[c] = wr_state_q[c];
      wr_cnt_d[c]   = wr_cnt_q[c];
      wr_addr_d[c]  = wr_addr_q[c];
      wr_data_d[c]  = wr_data_q[c];
      wr_fire[c]    = 1'b0;
      case (wr_state_q[c])
        S_IDLE: if (mem.mem_write_valid[c]) begin
          wr_addr_d[c] = mem.mem_write_address[c];
          wr_data_d[c] = mem.mem_write_data[c];
          wr_cnt_d[c]  = WR_LOAD;
          if (WRITE_LATENCY == 1) begin
            wr_state_d[c] = S_RESP;
            wr_fire[c]    = 1'b1;
          end else begin
            wr_state_d[c] = S_WAIT;
          end
        end
        S_WAIT: begin
          if (!mem.mem_write_valid[c]) begin
            wr_state_d[c] = S_IDLE;
          end else if (wr_cnt_q[c] == '0) begin
            wr_state_d[c] = S_RESP;
            wr_fire[c]    = 1'b1;
          end else begin
            wr_cnt_d[c] = wr_cnt_q[c] - WCW'(1);
          end
        end
        S_RESP:  wr_state_d[c] = S_REARM;
        S_REARM: if (!mem.mem_write_valid[c]) wr_state_d[c] = S_IDLE;
        default: wr_state_d[c] = S_IDLE;
      endcase
    end
  end

  // Load first, then channels in ascending order: the highest channel wins a collision.
  always_comb begin
    mem_d = mem_q;
    if (load_enable) mem_d[load_address] = load_data;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wr_fire[c]) mem_d[wr_addr_d[c]] = wr_data_d[c];
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rd_data_d[c] = rd_fire[c] ? mem_q[rd_addr_d[c]] : rd_data_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= '{default: S_IDLE};
      rd_cnt_q   <= '{default: '0};
      rd_addr_q  <= '{default: '0};
      rd_data_q  <= '{default: '0};
      wr_state_q <= '{default: S_IDLE};
      wr_cnt_q   <= '{default: '0};
      wr_addr_q  <= '{default: '0};
      wr_data_q  <= '{default: '0};
      mem_q      <= '{default: '0};
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      mem.mem_read_ready[c]  = (rd_state_q[c] == S_RESP);
      mem.mem_write_ready[c] = (wr_state_q[c] == S_RESP);
      mem.mem_read_data[c]   = rd_data_q[c];
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with default latencies
// and one with WRITE_LATENCY=3 for multi-cycle write and abort behaviour.
module tb_data_mem_responder;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_enable, ld3_en;
  logic [AB-1:0] load_address, ld3_addr;
  logic [DB-1:0] load_data, ld3_data;
  int            checks = 0;
  int            failures = 0;
  logic [AB-1:0] pre_a [5];
  logic [DB-1:0] pre_d [5];
  logic [DB-1:0] exp_d;

  always #5 clk = ~clk;

  data_mem_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) bus ();
  data_mem_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) bus3 ();

  data_mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC),
                       .READ_LATENCY(2), .WRITE_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .load_enable(load_enable),
    .load_address(load_address), .load_data(load_data), .mem(bus));

  data_mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC),
                       .READ_LATENCY(2), .WRITE_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .load_enable(ld3_en),
    .load_address(ld3_addr), .load_data(ld3_data), .mem(bus3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.mem_read_valid   = '0;
    bus.mem_write_valid  = '0;
    bus3.mem_read_valid  = '0;
    bus3.mem_write_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    load_enable = 1'b0; load_address = '0; load_data = '0;
    ld3_en = 1'b0; ld3_addr = '0; ld3_data = '0;
    idle_all();
    for (int c = 0; c < NC; c++) begin
      bus.mem_read_address[c] = '0;  bus.mem_write_address[c] = '0;  bus.mem_write_data[c] = '0;
      bus3.mem_read_address[c] = '0; bus3.mem_write_address[c] = '0; bus3.mem_write_data[c] = '0;
    end
    pre_a[0] = 8'h10; pre_d[0] = 8'hA5;
    pre_a[1] = 8'h50; pre_d[1] = 8'hC0;
    pre_a[2] = 8'h61; pre_d[2] = 8'hC1;
    pre_a[3] = 8'h72; pre_d[3] = 8'hC2;
    pre_a[4] = 8'h83; pre_d[4] = 8'hC3;
    step(); step();
    chk("rst_rready", 32'(bus.mem_read_ready), 32'h0);
    chk("rst_wready", 32'(bus.mem_write_ready), 32'h0);
    for (int c = 0; c < NC; c++) chk($sformatf("rst_rdata%0d", c), 32'(bus.mem_read_data[c]), 32'h0);
    reset = 1'b0;

    // Preload through the backdoor port
    load_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_address = pre_a[i]; load_data = pre_d[i];
      step();
    end
    load_enable = 1'b0;

    // Ch0 read 0x10, valid held through response and rearm
    bus.mem_read_valid[0] = 1'b1; bus.mem_read_address[0] = 8'h10;
    step(); chk("t1_edge_k", 32'(bus.mem_read_ready), 32'h0);
    step(); chk("t1_edge_k1", 32'(bus.mem_read_ready), 32'h0);
    step(); chk("t1_ready", 32'(bus.mem_read_ready), 32'h1);
    chk("t1_data", 32'(bus.mem_read_data[0]), 32'hA5);
    step(); chk("t1_rearm", 32'(bus.mem_read_ready), 32'h0);
    step(); chk("t1_rearm_hold", 32'(bus.mem_read_ready), 32'h0);
    chk("t1_data_hold", 32'(bus.mem_read_data[0]), 32'hA5);
    idle_all(); step(); step();

    // Ch2 write 0x3C to 0x20, then ch1 reads it back
    bus.mem_write_valid[2] = 1'b1; bus.mem_write_address[2] = 8'h20; bus.mem_write_data[2] = 8'h3C;
    step(); chk("t2_wready", 32'(bus.mem_write_ready), 32'h4);
    step(); chk("t2_wrearm", 32'(bus.mem_write_ready), 32'h0);
    idle_all(); step(); step();
    bus.mem_read_valid[1] = 1'b1; bus.mem_read_address[1] = 8'h20;
    step(); step(); step();
    chk("t2_rready", 32'(bus.mem_read_ready), 32'h2);
    chk("t2_rdata", 32'(bus.mem_read_data[1]), 32'h3C);
    idle_all(); step(); step();

    // Read entering RESP on the same edge as a write commit sees old data
    bus.mem_read_valid[1] = 1'b1; bus.mem_read_address[1] = 8'h30;
    step(); step();
    bus.mem_write_valid[0] = 1'b1; bus.mem_write_address[0] = 8'h30; bus.mem_write_data[0] = 8'h77;
    step();
    chk("t2s_rready", 32'(bus.mem_read_ready), 32'h2);
    chk("t2s_wready", 32'(bus.mem_write_ready), 32'h1);
    chk("t2s_old_data", 32'(bus.mem_read_data[1]), 32'h00);
    idle_all(); step(); step();
    bus.mem_read_valid[1] = 1'b1; bus.mem_read_address[1] = 8'h30;
    step(); step(); step();
    chk("t2s_new_data", 32'(bus.mem_read_data[1]), 32'h77);
    idle_all(); step(); step();

    // Same-address collision: ch0/1/3 plus load, ch3 must win
    bus.mem_write_valid = 4'b1011;
    bus.mem_write_address[0] = 8'h40; bus.mem_write_data[0] = 8'h11;
    bus.mem_write_address[1] = 8'h40; bus.mem_write_data[1] = 8'h22;
    bus.mem_write_address[3] = 8'h40; bus.mem_write_data[3] = 8'h33;
    load_enable = 1'b1; load_address = 8'h40; load_data = 8'h44;
    step(); chk("t3_wready", 32'(bus.mem_write_ready), 32'hB);
    idle_all(); load_enable = 1'b0; step(); step();
    bus.mem_read_valid[0] = 1'b1; bus.mem_read_address[0] = 8'h40;
    step(); step(); step();
    chk("t3_winner", 32'(bus.mem_read_data[0]), 32'h33);
    idle_all(); step(); step();

    // All channels read concurrently
    bus.mem_read_valid = 4'hF;
    for (int c = 0; c < NC; c++) bus.mem_read_address[c] = pre_a[c+1];
    step(); step(); chk("t4_early", 32'(bus.mem_read_ready), 32'h0);
    step(); chk("t4_ready", 32'(bus.mem_read_ready), 32'hF);
    for (int c = 0; c < NC; c++) begin
      exp_d = 8'hC0 + 8'(c);
      chk($sformatf("t4_data%0d", c), 32'(bus.mem_read_data[c]), 32'(exp_d));
    end
    idle_all(); step(); step();

    // Read abort in WAIT: no pulse, previous data kept
    bus.mem_read_valid[3] = 1'b1; bus.mem_read_address[3] = 8'h10;
    step(); idle_all();
    step(); chk("ra_none0", 32'(bus.mem_read_ready), 32'h0);
    step(); chk("ra_none1", 32'(bus.mem_read_ready), 32'h0);
    chk("ra_data_kept", 32'(bus.mem_read_data[3]), 32'hC3);

    // WRITE_LATENCY=3 instance: aborted write, then a full write
    ld3_en = 1'b1; ld3_addr = 8'h90; ld3_data = 8'h99;
    step(); ld3_en = 1'b0;
    bus3.mem_write_valid[0] = 1'b1; bus3.mem_write_address[0] = 8'h90; bus3.mem_write_data[0] = 8'h01;
    step(); idle_all();
    for (int i = 0; i < 4; i++) begin
      step(); chk($sformatf("t5_abort_nr%0d", i), 32'(bus3.mem_write_ready), 32'h0);
    end
    bus3.mem_write_valid[0] = 1'b1; bus3.mem_write_address[0] = 8'h91; bus3.mem_write_data[0] = 8'h5E;
    for (int i = 0; i < 3; i++) begin
      step(); chk($sformatf("t5_wait%0d", i), 32'(bus3.mem_write_ready), 32'h0);
    end
    step(); chk("t5_wready", 32'(bus3.mem_write_ready), 32'h1);
    idle_all(); step(); step();
    bus3.mem_read_valid = 4'b0011;
    bus3.mem_read_address[0] = 8'h90; bus3.mem_read_address[1] = 8'h91;
    step(); step(); step();
    chk("t5_unchanged", 32'(bus3.mem_read_data[0]), 32'h99);
    chk("t5_written", 32'(bus3.mem_read_data[1]), 32'h5E);
    idle_all(); step(); step();

    // Reset while a read is in WAIT
    bus.mem_read_valid[2] = 1'b1; bus.mem_read_address[2] = 8'h10;
    step(); step();
    reset = 1'b1;
    step(); chk("t6_rst_ready", 32'(bus.mem_read_ready), 32'h0);
    reset = 1'b0; idle_all();
    step(); chk("t6_after_ready", 32'(bus.mem_read_ready), 32'h0);
    step(); chk("t6_after_ready2", 32'(bus.mem_read_ready), 32'h0);
    chk("t6_rdata_clr", 32'(bus.mem_read_data[2]), 32'h0);
    bus.mem_write_valid[3] = 1'b1; bus.mem_write_address[3] = 8'h10; bus.mem_write_data[3] = 8'hBE;
    step(); chk("t6_wready", 32'(bus.mem_write_ready), 32'h8);
    idle_all(); step(); step();
    bus.mem_read_valid = 4'b0011;
    bus.mem_read_address[0] = 8'h10; bus.mem_read_address[1] = 8'h20;
    step(); step(); step();
    chk("t6_ready", 32'(bus.mem_read_ready), 32'h3);
    chk("t6_new_write", 32'(bus.mem_read_data[0]), 32'hBE);
    chk("t6_array_clr", 32'(bus.mem_read_data[1]), 32'h00);
    idle_all(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
